// File: rtl/input_quantizer_packer.sv
// input_quantizer_packer
//   Front end of the LogicNet inference path. Each accepted raw sample is
//   quantized to a 2-bit code against three run-time programmable thresholds
//   belonging to its feature position. NUM_FEATURES codes are packed into one
//   vector, which is offered downstream once per frame.
//
// Ports
//   clk, rst           clock (rising edge), async active-high reset
//   s_valid/s_ready    raw sample handshake; s_data sample, s_last frame end
//   m_valid/m_ready    packed vector handshake; m_data feature i at [2i+1:2i]
//   cfg_we/cfg_feat/cfg_sel/cfg_data
//                      threshold write port (sel 3 or feat out of range ignored)
//   frame_err          sticky framing error, cleared only by rst

// Per-feature lane: owns the three thresholds of one feature and produces the
// code the current sample would get if it belonged to this feature.
module iqp_lane #(
  parameter int              IN_WIDTH = 16,
  parameter logic [IN_WIDTH-1:0] THR0_INIT = 16'h1000,
  parameter logic [IN_WIDTH-1:0] THR1_INIT = 16'h4000,
  parameter logic [IN_WIDTH-1:0] THR2_INIT = 16'hC000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [1:0]          sel,
  input  logic [IN_WIDTH-1:0] wdata,
  input  logic [IN_WIDTH-1:0] sample,
  output logic [1:0]          code
);
  logic [2:0][IN_WIDTH-1:0] thr;
  logic [2:0]               ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr[0] <= THR0_INIT;
      thr[1] <= THR1_INIT;
      thr[2] <= THR2_INIT;
    end else if (we) begin
      case (sel)
        2'd0:    thr[0] <= wdata;
        2'd1:    thr[1] <= wdata;
        2'd2:    thr[2] <= wdata;
        default: ;
      endcase
    end
  end

  // Code is a population count of threshold hits, so thresholds need no
  // particular ordering.
  always_comb begin
    for (int k = 0; k < 3; k++) ge[k] = (sample >= thr[k]);
    code = {1'b0, ge[0]} + {1'b0, ge[1]} + {1'b0, ge[2]};
  end
endmodule

module input_quantizer_packer #(
  parameter int                  IN_WIDTH     = 16,
  parameter int                  NUM_FEATURES = 3,
  parameter logic [IN_WIDTH-1:0] THR0_INIT    = 16'h1000,
  parameter logic [IN_WIDTH-1:0] THR1_INIT    = 16'h4000,
  parameter logic [IN_WIDTH-1:0] THR2_INIT    = 16'hC000,
  localparam int                 FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*NUM_FEATURES-1:0] m_data,
  input  logic                      cfg_we,
  input  logic [FW-1:0]             cfg_feat,
  input  logic [1:0]                cfg_sel,
  input  logic [IN_WIDTH-1:0]       cfg_data,
  output logic                      frame_err
);
  localparam logic [FW-1:0] LAST = FW'(NUM_FEATURES - 1);

  logic [NUM_FEATURES-1:0][1:0] lane_code;
  logic [NUM_FEATURES-1:0][1:0] acc;
  logic [NUM_FEATURES-1:0][1:0] vec;
  logic [FW-1:0]                cnt;
  logic [1:0]                   cur_code;
  logic                         at_last;
  logic                         accept;

  // Every lane sees the sample; only the lane at the counter position matters.
  // Lanes whose index never matches cfg_feat (feat >= NUM_FEATURES) never write.
  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_lane
    iqp_lane #(
      .IN_WIDTH (IN_WIDTH),
      .THR0_INIT(THR0_INIT),
      .THR1_INIT(THR1_INIT),
      .THR2_INIT(THR2_INIT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we && (cfg_feat == FW'(f))),
      .sel   (cfg_sel),
      .wdata (cfg_data),
      .sample(s_data),
      .code  (lane_code[f])
    );
  end

  always_comb begin
    cur_code = '0;
    for (int f = 0; f < NUM_FEATURES; f++)
      if (cnt == FW'(f)) cur_code = lane_code[f];
  end

  assign at_last = (cnt == LAST);
  // Only the last feature has to wait for the held vector; a same-cycle
  // m_ready frees the output register in time for the new vector.
  assign s_ready = !(at_last && m_valid && !m_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    vec          = acc;
    vec[NUM_FEATURES-1] = cur_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (accept) begin
        if (at_last) begin
          // Vector goes out even when s_last is missing; only the flag records it.
          m_data  <= vec;
          m_valid <= 1'b1;
          cnt     <= '0;
          if (!s_last) frame_err <= 1'b1;
        end else if (s_last) begin
          // Early s_last: drop the partial frame and resynchronise.
          frame_err <= 1'b1;
          cnt       <= '0;
        end else begin
          acc[cnt] <= cur_code;
          cnt      <= cnt + FW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_input_quantizer_packer.sv
module tb_input_quantizer_packer;
  localparam int W  = 16;
  localparam int N  = 3;
  localparam int FW = 2;
  localparam logic [W-1:0] I0 = 16'h1000, I1 = 16'h4000, I2 = 16'hC000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, cfg_we = 1'b0;
  logic [W-1:0]   s_data = '0, cfg_data = '0;
  logic [FW-1:0]  cfg_feat = '0;
  logic [1:0]     cfg_sel = '0;
  logic           s_ready, m_valid, frame_err;
  logic [2*N-1:0] m_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_quantizer_packer #(.IN_WIDTH(W), .NUM_FEATURES(N),
    .THR0_INIT(I0), .THR1_INIT(I1), .THR2_INIT(I2)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_feat(cfg_feat), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .frame_err(frame_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]   mthr [N][3];
  logic [1:0]     mcodes [N];
  int             mcnt;
  logic           mv, mferr;
  logic [2*N-1:0] md;

  function automatic int quant(input logic [W-1:0] d, input int f);
    int n = 0;
    for (int k = 0; k < 3; k++) if (d >= mthr[f][k]) n++;
    return n;
  endfunction

  function automatic logic exp_sready();
    return !(mcnt == N-1 && mv && !m_ready);
  endfunction

  int             mc;
  logic [2*N-1:0] mvec;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < N; f++) begin
        mthr[f][0] <= I0; mthr[f][1] <= I1; mthr[f][2] <= I2;
      end
      mcnt <= 0; mv <= 1'b0; md <= '0; mferr <= 1'b0;
    end else begin
      if (mv && m_ready) mv <= 1'b0;
      if (s_valid && exp_sready()) begin
        mc = quant(s_data, mcnt);
        if (mcnt == N-1) begin
          for (int i = 0; i < N-1; i++) mvec[2*i +: 2] = mcodes[i];
          mvec[2*(N-1) +: 2] = 2'(mc);
          md <= mvec; mv <= 1'b1; mcnt <= 0;
          if (!s_last) mferr <= 1'b1;
        end else if (s_last) begin
          mferr <= 1'b1; mcnt <= 0;
        end else begin
          mcodes[mcnt] <= 2'(mc); mcnt <= mcnt + 1;
        end
      end
      if (cfg_we && cfg_sel != 2'd3 && int'(cfg_feat) < N)
        mthr[cfg_feat][cfg_sel] <= cfg_data;
    end
  end

  // Cycle-by-cycle comparison; inputs change only just after posedge.
  always @(negedge clk) begin
    chk("s_ready",   {31'd0, s_ready},   {31'd0, exp_sready()});
    chk("m_valid",   {31'd0, m_valid},   {31'd0, mv});
    chk("m_data",    {26'd0, m_data},    {26'd0, md});
    chk("frame_err", {31'd0, frame_err}, {31'd0, mferr});
  end

  // ---------------- stimulus helpers ----------------
  // Entered and left at posedge+1; waits a bounded number of cycles for accept.
  task automatic send(input logic [W-1:0] d, input logic last);
    logic r;
    int   n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    forever begin
      #1 r = s_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_data();
    logic [W-1:0] base;
    case ($urandom_range(0, 3))
      0: base = I0; 1: base = I1; 2: base = I2;
      default: return W'($urandom);
    endcase
    return base + W'($urandom_range(0, 2)) - W'(1);
  endfunction

  time t0;
  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data",  {26'd0, m_data}, 32'd0);
    chk("rst_ferr",    {31'd0, frame_err}, 32'd0);

    // basic frame with default thresholds
    m_ready = 1'b1;
    send(16'h0800, 0); send(16'h4000, 0); send(16'hFFFF, 1);
    chk("basic_valid", {31'd0, m_valid}, 32'd1);
    chk("basic_data",  {26'd0, m_data}, 32'b111000);
    chk("basic_ferr",  {31'd0, frame_err}, 32'd0);
    idle(1);

    // threshold boundaries
    send(16'h1000, 0); send(16'h0FFF, 0); send(16'hC000, 1);
    chk("bound_data", {26'd0, m_data}, 32'b110001);
    idle(1);

    // backpressure: hold a vector, next frame stalls only at its last feature
    m_ready = 1'b0;
    send(16'h0000, 0); send(16'h0000, 0); send(16'h0000, 1);
    send(16'hFFFF, 0); send(16'hFFFF, 0);
    s_valid = 1'b1; s_data = 16'h4000; s_last = 1'b1;
    #1 chk("bp_stall", {31'd0, s_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_hold_data", {26'd0, m_data}, 32'd0);
    m_ready = 1'b1;
    #1 chk("bp_release", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp_new_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_new_data", {26'd0, m_data}, 32'b101111);
    idle(1);

    // back-to-back frames: one beat per cycle, no bubbles
    t0 = $time;
    for (int fr = 0; fr < 3; fr++) begin
      send(16'h2000, 0); send(16'h5000, 0); send(16'hD000, 1);
    end
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd9);
    idle(1);

    // early s_last
    send(16'h2000, 0); send(16'h2000, 1);
    chk("early_ferr",  {31'd0, frame_err}, 32'd1);
    chk("early_valid", {31'd0, m_valid}, 32'd0);
    send(16'hC000, 0); send(16'h4000, 0); send(16'h1000, 1);
    chk("recover_data", {26'd0, m_data}, 32'b011011);
    chk("recover_ferr", {31'd0, frame_err}, 32'd1);
    idle(1);

    // config write in the same cycle as the affected sample
    send(16'h0000, 0);
    cfg_we = 1'b1; cfg_feat = 2'd1; cfg_sel = 2'd0; cfg_data = 16'h0000;
    send(16'h0010, 0);
    cfg_we = 1'b0;
    send(16'h0000, 1);
    chk("cfg_old_thr", {26'd0, m_data}, 32'b000000);
    send(16'h0000, 0); send(16'h0010, 0); send(16'h0000, 1);
    chk("cfg_new_thr", {26'd0, m_data}, 32'b000100);
    idle(1);

    // reset mid-frame
    send(16'h0000, 0); send(16'h0010, 0);
    rst = 1'b1;
    #1 chk("midrst_valid", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    send(16'h0000, 0); send(16'h0010, 0); send(16'h0000, 1);
    chk("midrst_data", {26'd0, m_data}, 32'b000000);
    chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
    idle(1);

    // randomized traffic, config writes and framing errors
    for (int c = 0; c < 3000; c++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      s_data   = pick_data();
      s_last   = ($urandom_range(0, 15) == 0) ? 1'($urandom) : (mcnt == N-1);
      m_ready  = ($urandom_range(0, 2) != 0);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_feat = FW'($urandom);
      cfg_sel  = 2'($urandom);
      cfg_data = pick_data();
      @(posedge clk); #1;
    end
    s_valid = 1'b0; cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
